test_06_encoder: RTL and testbench



---
 rtl/test_06_encoder.sv | 73 +++++++
 tb/tb_test_06_encoder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/test_06_encoder.sv
// ============================================================================
// Module   : test_06_encoder
// Purpose  : Registered 8-to-3 priority encoder (MSB wins) with a valid flag.
//            Optional multi-hot err output when TEST_06_ONEHOT_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_06_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  output logic [2:0] y,
`ifdef TEST_06_ONEHOT_ERR_EN
  output logic       err,
`endif
  output logic       valid
);

  logic [2:0] w_idx;
  logic       w_any;

  // Ascending scan so the last set bit seen (the MSB) overrides lower ones.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) w_idx = 3'(i);
    end
  end

  assign w_any = |a;

  logic [2:0] r_y;
  logic       r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      r_y     <= w_idx;
      r_valid <= w_any;
    end
  end

  assign y     = r_y;
  assign valid = r_valid;

`ifdef TEST_06_ONEHOT_ERR_EN
  logic [3:0] w_pop;
  logic       w_multi;
  logic       r_err;

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'd0, a[i]};
    end
  end

  assign w_multi = (w_pop >= 4'd2);

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_multi;
  end

  assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_test_06_encoder.sv
// Self-checking bench for test_06_encoder: directed cases plus random stimulus
// against an arithmetic reference model.
`default_nettype none

module tb_test_06_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [2:0] y;
  logic       valid;
`ifdef TEST_06_ONEHOT_ERR_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  test_06_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .y     (y),
`ifdef TEST_06_ONEHOT_ERR_EN
    .err   (err),
`endif
    .valid (valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: index of highest set bit is clog2(a+1)-1 for nonzero a.
  function automatic int ref_y(input logic r, input logic [7:0] v);
    if (r || v == 8'd0) return 0;
    return $clog2(int'(v) + 1) - 1;
  endfunction

  function automatic int ref_valid(input logic r, input logic [7:0] v);
    return (!r && v != 8'd0) ? 1 : 0;
  endfunction

  function automatic int ref_err(input logic r, input logic [7:0] v);
    return (!r && $countones(v) >= 2) ? 1 : 0;
  endfunction

  // Apply inputs for one edge, check outputs after it, then wiggle a and
  // confirm the registered outputs do not follow it before the next edge.
  task automatic step(input logic r, input logic [7:0] v, input string tag);
    int ey, ev, ee;
    @(negedge clk);
    rst = r;
    a   = v;
    @(posedge clk);
    #1;
    ey = ref_y(r, v);
    ev = ref_valid(r, v);
    ee = ref_err(r, v);
    check({tag, ".y"},     32'(y),     32'(ey));
    check({tag, ".valid"}, 32'(valid), 32'(ev));
`ifdef TEST_06_ONEHOT_ERR_EN
    check({tag, ".err"},   32'(err),   32'(ee));
`endif
    a = ~v;
    #2;
    check({tag, ".hold_y"},     32'(y),     32'(ey));
    check({tag, ".hold_valid"}, 32'(valid), 32'(ev));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq [4];
    logic [7:0] v;
    logic       r;
    rst = 1'b1;
    a   = 8'h00;

    // Reset holds outputs at zero even with all requests set
    step(1'b1, 8'hFF, "rst0");
    step(1'b1, 8'hFF, "rst1");
    step(1'b0, 8'hFF, "rel");

    seq = '{8'h10, 8'h80, 8'h40, 8'h04};
    foreach (seq[i]) step(1'b0, seq[i], "onehot_seq");

    for (int i = 0; i < 8; i++) step(1'b0, 8'(1 << i), "sweep");

    step(1'b0, 8'h00, "zero");
    step(1'b0, 8'h01, "bit0");

    step(1'b0, 8'h81, "multi81");
    step(1'b0, 8'h0C, "multi0C");
    step(1'b0, 8'h06, "multi06");
    step(1'b0, 8'h20, "single20");

    step(1'b0, 8'h40, "pre_rst");
    step(1'b1, 8'h40, "mid_rst");
    step(1'b0, 8'h02, "post_rst");

    for (int i = 0; i < 300; i++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = 8'(1 << $urandom_range(0, 7));
      r = ($urandom_range(0, 15) == 0);
      step(r, v, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
